// File: rtl/meas_seq_ctrl.sv
// meas_seq_ctrl
// Measurement round sequencer. Every period it starts a round that walks the
// enabled channels from lowest to highest, kicking the shared measurement
// datapath with a one-cycle start pulse and waiting for its done pulse (or a
// timeout). Each result is presented on a valid/ready stream before the next
// channel is started. Round boundaries and dropped period ticks are flagged
// with one-cycle pulses.

module meas_seq_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 16,
  parameter int PERIOD_W    = 24,
  parameter int TIMEOUT_CYC = 1000,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_ni,
  input  logic              enable_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic              meas_start_o,
  output logic [CH_W-1:0]   meas_ch_o,
  input  logic              meas_done_i,
  input  logic [DATA_W-1:0] meas_data_i,
  output logic              res_valid_o,
  output logic [CH_W-1:0]   res_ch_o,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_to_o,
  input  logic              res_ready_i,
  output logic              round_done_o,
  output logic              overrun_o,
  output logic              busy_o
);

  // Timeout counter only needs to reach TIMEOUT_CYC-1.
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

  // Sequencer states. IDLE/WAIT are the "not busy" states.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_MEAS  = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [CH_W-1:0]     ptr_q, ptr_d;
  // Channels of the current round that still have to be started.
  logic [NUM_CH-1:0]   remMask_q, remMask_d;
  logic [TO_W-1:0]     toCnt_q, toCnt_d;
  logic [PERIOD_W-1:0] perCnt_q, perCnt_d;
  logic [PERIOD_W-1:0] perLim_q, perLim_d;
  logic [CH_W-1:0]     resCh_q, resCh_d;
  logic [DATA_W-1:0]   resData_q, resData_d;
  logic                resTo_q, resTo_d;
  logic                roundDone_q, roundDone_d;
  logic                overrun_q, overrun_d;

  logic [PERIOD_W-1:0] perLast;
  logic                tick;
  logic                roundStart;
  logic                busy;

  // Index of the lowest set bit; callers only use it on non-zero vectors.
  function automatic logic [CH_W-1:0] lowestSet(input logic [NUM_CH-1:0] vec);
    logic [CH_W-1:0] idx;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = CH_W'(i);
    end
    return idx;
  endfunction

  // A period of 0 behaves like 1, so the wrap value saturates at 0.
  assign perLast = (perLim_q == '0) ? '0 : (perLim_q - PERIOD_W'(1));
  assign busy    = (state_q == S_START) || (state_q == S_MEAS) || (state_q == S_OUT);
  assign tick    = enable_i && (state_q != S_IDLE) && (perCnt_q == perLast);

  // Sequencer next-state logic, including round start and result capture.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remMask_d   = remMask_q;
    toCnt_d     = toCnt_q;
    resCh_d     = resCh_q;
    resData_d   = resData_q;
    resTo_d     = resTo_q;
    roundDone_d = 1'b0;
    overrun_d   = 1'b0;
    roundStart  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable_i) roundStart = 1'b1;
      end
      S_WAIT: begin
        if (!enable_i) begin
          state_d = S_IDLE;
        end else if (tick) begin
          roundStart = 1'b1;
        end
      end
      S_START: begin
        state_d = S_MEAS;
        toCnt_d = '0;
      end
      S_MEAS: begin
        if (meas_done_i) begin
          resCh_d   = ptr_q;
          resData_d = meas_data_i;
          resTo_d   = 1'b0;
          state_d   = S_OUT;
        end else if (toCnt_q == TO_LAST) begin
          resCh_d   = ptr_q;
          resData_d = '0;
          resTo_d   = 1'b1;
          state_d   = S_OUT;
        end else begin
          toCnt_d = toCnt_q + TO_W'(1);
        end
      end
      S_OUT: begin
        if (res_ready_i) begin
          if (!enable_i) begin
            state_d = S_IDLE;
          end else if (remMask_q != '0) begin
            ptr_d     = lowestSet(remMask_q);
            remMask_d = remMask_q & (remMask_q - NUM_CH'(1));
            state_d   = S_START;
          end else begin
            roundDone_d = 1'b1;
            state_d     = S_WAIT;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The mask is sampled only here; an empty mask closes the round at once.
    if (roundStart) begin
      ptr_d     = lowestSet(ch_mask_i);
      remMask_d = ch_mask_i & (ch_mask_i - NUM_CH'(1));
      if (ch_mask_i == '0) begin
        roundDone_d = 1'b1;
        state_d     = S_WAIT;
      end else begin
        state_d = S_START;
      end
    end

    if (tick && busy) overrun_d = 1'b1;
  end

  // Period counter: restarts on each round start, wraps on every tick.
  always_comb begin
    perCnt_d = perCnt_q;
    perLim_d = perLim_q;
    if (roundStart) begin
      perCnt_d = '0;
      perLim_d = period_i;
    end else if (state_q == S_IDLE) begin
      perCnt_d = '0;
    end else if (enable_i) begin
      if (tick) begin
        perCnt_d = '0;
        perLim_d = period_i;
      end else begin
        perCnt_d = perCnt_q + PERIOD_W'(1);
      end
    end
  end

  // Control state and counters.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      remMask_q <= '0;
      toCnt_q   <= '0;
      perCnt_q  <= '0;
      perLim_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      remMask_q <= remMask_d;
      toCnt_q   <= toCnt_d;
      perCnt_q  <= perCnt_d;
      perLim_q  <= perLim_d;
    end
  end

  // Result holding registers and event pulses.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      resCh_q     <= '0;
      resData_q   <= '0;
      resTo_q     <= 1'b0;
      roundDone_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      resCh_q     <= resCh_d;
      resData_q   <= resData_d;
      resTo_q     <= resTo_d;
      roundDone_q <= roundDone_d;
      overrun_q   <= overrun_d;
    end
  end

  assign meas_start_o = (state_q == S_START);
  assign meas_ch_o    = ptr_q;
  assign res_valid_o  = (state_q == S_OUT);
  assign res_ch_o     = resCh_q;
  assign res_data_o   = resData_q;
  assign res_to_o     = resTo_q;
  assign round_done_o = roundDone_q;
  assign overrun_o    = overrun_q;
  assign busy_o       = busy;

endmodule

// File: tb/tb_meas_seq_ctrl.sv
// tb_meas_seq_ctrl
// Random and directed stimulus for meas_seq_ctrl, checked every cycle against
// a round/queue based reference model kept in this file.

module tb_meas_seq_ctrl;

  localparam int NUM_CH      = 4;
  localparam int DATA_W      = 16;
  localparam int PERIOD_W    = 24;
  localparam int TIMEOUT_CYC = 1000;
  localparam int CH_W        = 2;

  logic                clk = 1'b0;
  logic                reset_ni;
  logic                enable_i;
  logic [NUM_CH-1:0]   ch_mask_i;
  logic [PERIOD_W-1:0] period_i;
  logic                meas_start_o;
  logic [CH_W-1:0]     meas_ch_o;
  logic                meas_done_i;
  logic [DATA_W-1:0]   meas_data_i;
  logic                res_valid_o;
  logic [CH_W-1:0]     res_ch_o;
  logic [DATA_W-1:0]   res_data_o;
  logic                res_to_o;
  logic                res_ready_i;
  logic                round_done_o;
  logic                overrun_o;
  logic                busy_o;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  meas_seq_ctrl #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD_W(PERIOD_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .reset_ni(reset_ni), .enable_i(enable_i), .ch_mask_i(ch_mask_i),
    .period_i(period_i), .meas_start_o(meas_start_o), .meas_ch_o(meas_ch_o),
    .meas_done_i(meas_done_i), .meas_data_i(meas_data_i), .res_valid_o(res_valid_o),
    .res_ch_o(res_ch_o), .res_data_o(res_data_o), .res_to_o(res_to_o),
    .res_ready_i(res_ready_i), .round_done_o(round_done_o), .overrun_o(overrun_o),
    .busy_o(busy_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model of what the sequencer should show in the current cycle.
  bit          mInRound, mArmed, mStartNow, mMeasuring, mHolding;
  bit          mRoundDone, mOverrun, mResTo;
  int          mCur, mWaited, mSince, mLim, mResCh;
  logic [15:0] mResData;
  int          mPend[$];

  // Phase knobs for the stimulus generator.
  bit          phEn, phDropCh1, dropped, lateSent;
  logic [3:0]  phMask;
  int          phPer, phLatMin, phLatMax, phToPct, phSpurPct, phReadyPct, phHold;
  int          doneAt, heldCnt;

  // Observation counters, cleared per phase.
  int          obsStartCh[NUM_CH];
  int          obsRoundDone, obsOverrun, obsToResults, firstCh0, secondCh0;
  bit          prevValid;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic modelReset();
    mInRound = 0; mArmed = 0; mStartNow = 0; mMeasuring = 0; mHolding = 0;
    mRoundDone = 0; mOverrun = 0; mResTo = 0;
    mCur = 0; mWaited = 0; mSince = 0; mLim = 0; mResCh = 0; mResData = '0;
    mPend.delete();
    doneAt = -1; heldCnt = 0; lateSent = 0;
  endtask

  task automatic clearObs();
    for (int i = 0; i < NUM_CH; i++) obsStartCh[i] = 0;
    obsRoundDone = 0; obsOverrun = 0; obsToResults = 0;
    firstCh0 = -1; secondCh0 = -1;
  endtask

  // Advance the model across one clock edge using the inputs just driven.
  task automatic modelStep();
    bit wasIdle, tick, roundStart;
    wasIdle    = !mInRound && !mArmed;
    tick       = !wasIdle && enable_i && (mSince == ((mLim <= 1) ? 0 : mLim - 1));
    roundStart = 0;
    mRoundDone = 0;
    mOverrun   = 0;
    if (wasIdle) begin
      roundStart = enable_i;
    end else if (!mInRound) begin
      if (!enable_i) mArmed = 0;
      else if (tick) roundStart = 1;
    end else begin
      if (tick) mOverrun = 1;
      if (mStartNow) begin
        mStartNow = 0; mMeasuring = 1; mWaited = 0;
      end else if (mMeasuring) begin
        if (meas_done_i) begin
          mResData = meas_data_i; mResTo = 0; mResCh = mCur;
          mMeasuring = 0; mHolding = 1;
        end else if (mWaited == TIMEOUT_CYC - 1) begin
          mResData = '0; mResTo = 1; mResCh = mCur;
          mMeasuring = 0; mHolding = 1;
        end else begin
          mWaited++;
        end
      end else if (mHolding && res_ready_i) begin
        mHolding = 0;
        if (!enable_i) begin
          mInRound = 0; mArmed = 0;
        end else if (mPend.size() > 0) begin
          mCur = mPend.pop_front(); mStartNow = 1;
        end else begin
          mInRound = 0; mRoundDone = 1;
        end
      end
    end
    if (roundStart) begin
      mPend.delete();
      for (int i = 0; i < NUM_CH; i++) if (ch_mask_i[i]) mPend.push_back(i);
      mArmed = 1;
      if (mPend.size() == 0) begin
        mRoundDone = 1;
      end else begin
        mCur = mPend.pop_front(); mInRound = 1; mStartNow = 1;
      end
    end
    if (roundStart) begin
      mSince = 0; mLim = int'(period_i);
    end else if (wasIdle) begin
      mSince = 0;
    end else if (enable_i) begin
      if (tick) begin
        mSince = 0; mLim = int'(period_i);
      end else begin
        mSince++;
      end
    end
  endtask

  // Drive this cycle's inputs: enable, mask, period, datapath reply, ready.
  task automatic applyStimulus();
    if (phDropCh1 && mMeasuring && mCur == 1) dropped = 1;
    enable_i    = phEn && !dropped;
    ch_mask_i   = phMask;
    period_i    = PERIOD_W'(phPer);
    meas_done_i = 1'b0;
    meas_data_i = DATA_W'($urandom);
    if (mStartNow) begin
      lateSent = 0;
      if ($urandom_range(99) < phToPct) doneAt = -1;
      else doneAt = cyc + $urandom_range(phLatMax, phLatMin);
      if ($urandom_range(99) < phSpurPct) meas_done_i = 1'b1;
    end else if (doneAt == cyc) begin
      meas_done_i = 1'b1;
      doneAt = -1;
    end
    if (mHolding && mResTo && !lateSent) begin
      meas_done_i = 1'b1;
      lateSent = 1;
    end
    if (mHolding) res_ready_i = (heldCnt >= phHold) && ($urandom_range(99) < phReadyPct);
    else res_ready_i = ($urandom_range(1) == 1);
    if (mHolding) heldCnt++;
    else heldCnt = 0;
  endtask

  task automatic compareAll();
    checkOutput("meas_start", meas_start_o, mStartNow);
    checkOutput("busy", busy_o, mInRound);
    if (mInRound) checkOutput("meas_ch", meas_ch_o, mCur);
    checkOutput("res_valid", res_valid_o, mHolding);
    if (mHolding) begin
      checkOutput("res_ch", res_ch_o, mResCh);
      checkOutput("res_data", res_data_o, mResData);
      checkOutput("res_to", res_to_o, mResTo);
    end
    checkOutput("round_done", round_done_o, mRoundDone);
    checkOutput("overrun", overrun_o, mOverrun);
  endtask

  task automatic observe();
    if (meas_start_o) begin
      obsStartCh[meas_ch_o]++;
      if (meas_ch_o == 0) begin
        if (firstCh0 < 0) firstCh0 = cyc;
        else if (secondCh0 < 0) secondCh0 = cyc;
      end
    end
    if (round_done_o) obsRoundDone++;
    if (overrun_o) obsOverrun++;
    if (res_valid_o && !prevValid && res_to_o && res_data_o == '0) obsToResults++;
    prevValid = res_valid_o;
  endtask

  task automatic runCycle();
    @(negedge clk);
    compareAll();
    observe();
    applyStimulus();
    modelStep();
    cyc++;
  endtask

  task automatic runPhase(input int n);
    for (int k = 0; k < n; k++) runCycle();
  endtask

  // Drop enable and let the sequencer settle back to idle.
  task automatic runPause();
    int k;
    phEn = 0; phDropCh1 = 0; phHold = 0; phReadyPct = 100;
    k = 0;
    while (((mInRound || mArmed) || k < 3) && k < 3000) begin
      runCycle();
      k++;
    end
    checkOutput("pause_idle", {31'b0, mInRound | mArmed}, 0);
    dropped = 0;
    clearObs();
  endtask

  task automatic setPhase(input logic [3:0] mask, input int per, input int latMin,
                          input int latMax, input int toPct, input int spurPct,
                          input int readyPct, input int hold);
    phEn = 1; phMask = mask; phPer = per; phLatMin = latMin; phLatMax = latMax;
    phToPct = toPct; phSpurPct = spurPct; phReadyPct = readyPct; phHold = hold;
  endtask

  // Bound on total run time.
  initial begin
    #5000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence.
  initial begin
    reset_ni = 1'b0; enable_i = 0; ch_mask_i = '0; period_i = '0;
    meas_done_i = 0; meas_data_i = '0; res_ready_i = 0;
    phDropCh1 = 0; dropped = 0; prevValid = 0;
    modelReset();
    clearObs();
    #1;
    checkOutput("reset_busy", busy_o, 0);
    checkOutput("reset_start", meas_start_o, 0);
    checkOutput("reset_valid", res_valid_o, 0);
    checkOutput("reset_round_done", round_done_o, 0);
    repeat (3) @(negedge clk);
    reset_ni = 1'b1;

    $display("[TB] mask 1011, period 200, latency 3");
    runPause();
    setPhase(4'b1011, 200, 3, 3, 0, 0, 100, 0);
    runPhase(450);
    checkOutput("p1_round_spacing", secondCh0 - firstCh0, 200);
    checkOutput("p1_ch2_starts", obsStartCh[2], 0);
    checkOutput("p1_ch3_starts", obsStartCh[3], 3);

    $display("[TB] empty mask, period 10");
    runPause();
    setPhase(4'b0000, 10, 3, 3, 0, 0, 100, 0);
    runPhase(60);
    checkOutput("p2_round_done_count", obsRoundDone, 6);
    checkOutput("p2_no_starts", obsStartCh[0] + obsStartCh[1], 0);

    $display("[TB] datapath silent, timeouts");
    runPause();
    setPhase(4'b0011, 2500, 1, 1, 100, 0, 100, 0);
    runPhase(2100);
    checkOutput("p3_timeout_results", obsToResults, 2);
    checkOutput("p3_ch1_started", obsStartCh[1], 1);

    $display("[TB] period 5, latency 20");
    runPause();
    setPhase(4'b1111, 5, 20, 20, 0, 0, 100, 0);
    runPhase(300);
    checkOutput("p4_overrun_seen", {31'b0, obsOverrun > 0}, 1);

    $display("[TB] consumer stalls 50 cycles");
    runPause();
    setPhase(4'b0101, 400, 2, 6, 0, 0, 100, 50);
    runPhase(400);
    checkOutput("p5_ch2_started", obsStartCh[2], 1);

    $display("[TB] enable dropped during channel 1");
    runPause();
    setPhase(4'b0111, 300, 10, 10, 0, 0, 100, 0);
    phDropCh1 = 1;
    runPhase(200);
    checkOutput("p6_ch2_starts", obsStartCh[2], 0);
    checkOutput("p6_round_done", obsRoundDone, 0);
    checkOutput("p6_busy_end", busy_o, 0);

    $display("[TB] random phases");
    for (int r = 0; r < 6; r++) begin
      runPause();
      setPhase(4'($urandom_range(15)), $urandom_range(60), 1, 15, 2, 20,
               $urandom_range(100, 30), 0);
      runPhase(400);
    end

    $display("[TB] asynchronous reset during measurement");
    runPause();
    setPhase(4'b0001, 100, 1, 1, 100, 0, 100, 0);
    for (int k = 0; k < 100 && !(mMeasuring && mWaited > 5); k++) runCycle();
    checkOutput("p7_reached_meas", {31'b0, mMeasuring}, 1);
    @(negedge clk);
    #2;
    reset_ni = 1'b0;
    #1;
    checkOutput("areset_busy", busy_o, 0);
    checkOutput("areset_start", meas_start_o, 0);
    checkOutput("areset_valid", res_valid_o, 0);
    checkOutput("areset_meas_ch", meas_ch_o, 0);
    checkOutput("areset_res_data", res_data_o, 0);
    checkOutput("areset_pulses", {30'b0, round_done_o, overrun_o}, 0);
    modelReset();
    enable_i = 0; meas_done_i = 0; res_ready_i = 0;
    phEn = 0;
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    runPhase(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/meas_seq_ctrl.md
Name: meas_seq_ctrl

Overview:
Measurement sequencer for the measurement subsystem. It schedules periodic measurement rounds and, in each round, starts one measurement per enabled channel on the shared measurement datapath using a start/done handshake. It returns each result over a valid/ready stream, guarded by a per-measurement timeout. It sits between the top-level run-enable switch and the measurement datapath/result consumer inside the measurement top system.

Parameters:
NUM_CH, 4, number of measurement channels (2..16); CH_W = $clog2(NUM_CH)
DATA_W, 16, width of measurement result
PERIOD_W, 24, width of round period
TIMEOUT_CYC, 1000, max cycles waiting for meas_done_i (>=2)

Ports:
clk  in  1  system clock
reset_ni  in  1  asynchronous active-low reset
enable_i  in  1  run enable (level, synchronous to clk)
ch_mask_i  in  NUM_CH  channel enable mask, bit n = channel n
period_i  in  PERIOD_W  cycles between round starts; 0 or 1 = back-to-back
meas_start_o  out  1  one-cycle start pulse to datapath
meas_ch_o  out  CH_W  channel under measurement, stable from start to done
meas_done_i  in  1  datapath completion pulse
meas_data_i  in  DATA_W  result, valid with meas_done_i
res_valid_o  out  1  result valid
res_ch_o  out  CH_W  result channel
res_data_o  out  DATA_W  result data (0 on timeout)
res_to_o  out  1  result is a timeout
res_ready_i  in  1  consumer ready
round_done_o  out  1  one-cycle pulse, round finished
overrun_o  out  1  one-cycle pulse, period tick dropped (round still running)
busy_o  out  1  FSM not in IDLE/WAIT

Behaviour:
- Clock: clk only. Reset: reset_ni, asynchronous active-low. On reset every output is 0, FSM = IDLE, counters = 0.
- FSM states: IDLE, WAIT, START, MEAS, OUT.
- IDLE: enable_i=1 -> START in the next cycle (the first round starts immediately). Period counter is cleared.
- Period counter: runs while enable_i=1. A tick occurs when the count reaches max(period_i,1)-1; the count then wraps to 0. The counter restarts at 0 on every round start, so round starts are exactly period_i cycles apart. period_i is sampled at each wrap.
- Round start: ch_mask_i is latched. The channel pointer is set to the lowest set bit. A latched mask of all zeros -> round_done_o pulses, state -> WAIT, and meas_start_o is never asserted.
- START: meas_start_o=1 for exactly 1 cycle; meas_ch_o = pointer. State -> MEAS and the timeout counter is cleared.
- MEAS: meas_done_i asserted in the START cycle is ignored.
  - On meas_done_i: capture meas_data_i; res_to_o=0; -> OUT.
  - If TIMEOUT_CYC cycles elapse without done: res_data_o=0; res_to_o=1; -> OUT.
  - meas_done_i arriving after a timeout is ignored.
- OUT: res_valid_o=1. res_ch_o, res_data_o and res_to_o are held stable until the cycle res_ready_i=1 (transfer); res_valid_o drops in the cycle after the transfer.
  - If a higher enabled channel remains -> START for that channel (next cycle after the transfer).
  - Otherwise round_done_o pulses and -> WAIT.
  - Minimum channel-to-channel spacing is 2 cycles plus datapath latency.
- WAIT: tick -> START for the next round. enable_i=0 -> IDLE.
- Tick arriving while in START/MEAS/OUT: the tick is dropped and overrun_o pulses 1 cycle. The round continues, and the next round waits for the next tick.
- enable_i deasserted mid-round: the current channel completes, including its result handshake. No further channels are started, round_done_o is NOT pulsed, and the FSM -> IDLE.
- Mask bits outside NUM_CH do not exist. Mask changes mid-round have no effect until the next round start.
- busy_o = 1 in START, MEAS and OUT.

Test Plan:
1. Reset then enable_i=1, mask=4'b1011, period=200, datapath done 3 cycles after start, res_ready_i=1 -> start pulses on ch 0,1,3 in order. Results carry ch 0,1,3 with the exact data. round_done_o pulses once. The second round's start occurs exactly 200 cycles after the first.
2. mask=4'b0000, period=10 -> no meas_start_o. round_done_o pulses every 10 cycles.
3. Datapath never answers, TIMEOUT_CYC=1000 -> result after 1000 cycles with res_to_o=1 and res_data_o=0. A late meas_done_i is ignored and the sequence proceeds to the next channel.
4. period=5 with datapath latency 20 -> overrun_o pulses during the round and no round restarts mid-round. The next round starts on the first tick after round_done_o.
5. res_ready_i held low 50 cycles -> res_valid_o and res_data_o stay stable for 50 cycles. No new meas_start_o is issued until the cycle after the transfer.
6. enable_i dropped during MEAS of ch 1 (mask 4'b0111) -> ch 1's result is delivered, ch 2 is never started, round_done_o stays 0, and busy_o falls. Separately, asserting reset_ni=0 mid-MEAS clears all outputs immediately (asynchronously).
